// File: rtl/spi_inst_loader_pkg.sv
// Shared types and constants for the SPI instruction loader.
// Build option SPI_INST_LOADER_CHECKSUM_EN is consumed by spi_inst_loader.sv.
package spi_inst_loader_pkg;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned HDR_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [WORD_BITS-1:0] addr;
    logic [WORD_BITS-1:0] wdata;
  } mem_wr_t;

endpackage

// File: rtl/spi_loader_fifo.sv
// Synchronous write buffer between the SPI deserialiser and the memory port.
// DEPTH must be a power of two, at least 2. A pop frees a slot for a push in the same cycle.
module spi_loader_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_inst_loader.sv
// SPI-slave boot loader: header word gives payload count N, payload words are written to memory,
// then fetch enable is released. Define SPI_INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module spi_inst_loader
  import spi_inst_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned GAP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sel_i,
  input  logic                  spi_ss_i,
  input  logic                  spi_mosi_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  output logic                  fetch_en_o,
  output logic                  load_err_o,
  output logic [15:0]           words_o,
  output state_e                dbg_state_o
);

  localparam logic [7:0] GAP_LAST = (GAP_BITS == 0) ? 8'd0 : 8'(GAP_BITS - 1);

  state_e                  state_q, state_d, state_n;
  logic [4:0]              bit_cnt_q;
  logic [7:0]              gap_cnt_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [DATA_WIDTH-1:0]   word;
  logic                    shift_en, gap_en, abort, word_done;
  logic                    hdr_seen_q, hdr_seen_d;
  logic [HDR_CNT_W-1:0]    n_q, n_d, rcv_q, words_q, words_d;
  logic [31:0]             addr_q;
  logic                    fetch_q, fetch_d, err_q;
  logic                    payload_word, push, pop, drop, finish;
  logic                    fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0]   fifo_head;
  logic                    ck_ok_d, ck_fail;
  mem_wr_t                 wr;

  // SPI sequencing: sel_i high freezes the sequencer, slave-select high aborts the current word.
  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    gap_en   = 1'b0;
    if (!sel_i) begin
      unique case (state_q)
        IDLE: begin
          if (!spi_ss_i) begin
            state_d  = SHIFT;
            shift_en = 1'b1;
          end
        end
        SHIFT: begin
          if (spi_ss_i) begin
            state_d = IDLE;
          end else begin
            shift_en = 1'b1;
            if (bit_cnt_q == 5'd31) state_d = (GAP_BITS == 0) ? SHIFT : GAP;
          end
        end
        GAP: begin
          if (spi_ss_i) begin
            state_d = IDLE;
          end else begin
            gap_en = 1'b1;
            if (gap_cnt_q == GAP_LAST) state_d = SHIFT;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign state_n = finish ? DONE : state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_n;
  end

  assign abort        = !sel_i && spi_ss_i;
  assign word         = {shift_q[DATA_WIDTH-2:0], spi_mosi_i};
  assign word_done    = shift_en && (bit_cnt_q == 5'd31);
  assign payload_word = word_done && hdr_seen_q && (rcv_q < n_q);
  assign pop          = mem_req_o && mem_gnt_i;
  assign push         = payload_word && (!fifo_full || pop);
  assign drop         = payload_word && fifo_full && !pop;

  assign hdr_seen_d = hdr_seen_q || word_done;
  assign n_d        = (word_done && !hdr_seen_q) ? word[HDR_CNT_W-1:0] : n_q;
  assign words_d    = words_q + HDR_CNT_W'(pop);

`ifdef SPI_INST_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] xor_q;
  logic                  ck_ok_q;
  logic                  ck_word;

  // The word following payload N is the checksum; only the first one is judged.
  assign ck_word = word_done && hdr_seen_q && (rcv_q == n_q) && !ck_ok_q;
  assign ck_fail = ck_word && (word != xor_q);
  assign ck_ok_d = ck_ok_q || (ck_word && (word == xor_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xor_q   <= '0;
      ck_ok_q <= 1'b0;
    end else begin
      if (payload_word) xor_q <= xor_q ^ word;
      ck_ok_q <= ck_ok_d;
    end
  end
`else
  assign ck_ok_d = 1'b1;
  assign ck_fail = 1'b0;
`endif

  // Evaluated on next-state values so fetch enable rises the cycle after the final grant.
  assign fetch_d = hdr_seen_d && (words_d == n_d) && ck_ok_d;
  assign finish  = fetch_d || ck_fail;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      shift_q    <= '0;
      hdr_seen_q <= 1'b0;
      n_q        <= '0;
      rcv_q      <= '0;
      words_q    <= '0;
      addr_q     <= BASE_ADDR;
      fetch_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (shift_en)   bit_cnt_q <= bit_cnt_q + 5'd1;
      else if (abort) bit_cnt_q <= '0;
      if (gap_en)     gap_cnt_q <= (gap_cnt_q == GAP_LAST) ? 8'd0 : gap_cnt_q + 8'd1;
      else if (abort) gap_cnt_q <= '0;
      if (shift_en)   shift_q <= word;
      hdr_seen_q <= hdr_seen_d;
      n_q        <= n_d;
      if (payload_word) rcv_q <= rcv_q + HDR_CNT_W'(1);
      words_q    <= words_d;
      if (pop)    addr_q <= addr_q + 32'd4;
      fetch_q    <= fetch_q || fetch_d;
      err_q      <= err_q || drop || ck_fail;
    end
  end

  spi_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (word),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Memory handshake: mem_req_o is the valid, mem_gnt_i the ready; a beat moves on the cycle both
  // are high, and address/data hold unchanged until that cycle.
  assign wr.addr  = addr_q;
  assign wr.wdata = fifo_empty ? '0 : fifo_head;

  assign mem_req_o   = !fifo_empty;
  assign mem_we_o    = mem_req_o;
  assign mem_be_o    = {4{mem_req_o}};
  assign mem_addr_o  = wr.addr;
  assign mem_wdata_o = wr.wdata;
  assign fetch_en_o  = fetch_q;
  assign load_err_o  = err_q;
  assign words_o     = words_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_inst_loader.sv
// Directed bench for spi_inst_loader: SPI driver tasks, write scoreboard with a monitor, final report.
module tb_spi_inst_loader;
  import spi_inst_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        ss = 1'b1;
  logic        mosi = 1'b0;
  logic        gnt = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        fetch_en, load_err;
  logic [15:0] words;
  state_e      dbg_state;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  int          cyc = 0;
  int          last_gnt_cyc = -100;
  logic        prev_fetch = 1'b0;
  logic        chk_fetch_lat = 1'b0;

  always #5 clk = ~clk;

  spi_inst_loader dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sel_i       (sel),
    .spi_ss_i    (ss),
    .spi_mosi_i  (mosi),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_gnt_i   (gnt),
    .fetch_en_o  (fetch_en),
    .load_err_o  (load_err),
    .words_o     (words),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every granted beat is matched against the head of the expected queue.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (mem_req && gnt) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", mem_addr, mem_wdata);
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_addr", mem_addr, exp_e[63:32]);
          check("wr_data", mem_wdata, exp_e[31:0]);
          check("wr_we_be", {27'b0, mem_we, mem_be}, 32'h0000_001F);
        end
        last_gnt_cyc = cyc;
      end
      if (fetch_en && !prev_fetch && chk_fetch_lat)
        check("fetch_latency", 32'(cyc - last_gnt_cyc), 32'd1);
      prev_fetch = fetch_en;
    end else begin
      prev_fetch = 1'b0;
    end
  end

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      ss   = 1'b0;
      mosi = w[31-i];
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    shift_bits(w, 32);
    mosi = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_ck(input logic [31:0] w);
`ifdef SPI_INST_LOADER_CHECKSUM_EN
    send_word(w);
`else
    if (w === 32'hxxxx_xxxx) mosi = 1'b0;
`endif
  endtask

  task automatic end_frame();
    ss   = 1'b1;
    mosi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ss  = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_fetch(input int max_cyc);
    for (int i = 0; i < max_cyc && !fetch_en; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_be", {28'b0, mem_be}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_fetch", {31'b0, fetch_en}, 32'd0);
    check("rst_err", {31'b0, load_err}, 32'd0);
    check("rst_words", {16'b0, words}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Two payload words with grant tied high.
    gnt = 1'b1;
`ifndef SPI_INST_LOADER_CHECKSUM_EN
    chk_fetch_lat = 1'b1;
`endif
    expect_write(32'h0, 32'hDEAD_BEEF);
    expect_write(32'h4, 32'h0000_0013);
    send_word(32'h0000_0002);
    shift_bits(32'hDEAD_BEEF, 32);
    check("req_latency", {31'b0, mem_req}, 32'd1);
    mosi = 1'b0;
    @(posedge clk); #1;
    send_word(32'h0000_0013);
    send_ck(32'hDEAD_BEFC);
    end_frame();
    wait_fetch(40);
    check("t1_fetch", {31'b0, fetch_en}, 32'd1);
    check("t1_words", {16'b0, words}, 32'd2);
    check("t1_err", {31'b0, load_err}, 32'd0);
    check("t1_queue", 32'(exp_q.size()), 32'd0);
    check("t1_state", 32'(dbg_state), 32'(DONE));
    chk_fetch_lat = 1'b0;
    do_reset();

    // Grant held low: the third payload word meets a full buffer and is dropped.
    gnt = 1'b0;
    expect_write(32'h0, 32'h1111_0001);
    expect_write(32'h4, 32'h2222_0002);
    send_word(32'h0000_0003);
    send_word(32'h1111_0001);
    send_word(32'h2222_0002);
    send_word(32'h3333_0003);
    end_frame();
    check("t2_err", {31'b0, load_err}, 32'd1);
    check("t2_words_held", {16'b0, words}, 32'd0);
    check("t2_req_held", {31'b0, mem_req}, 32'd1);
    check("t2_addr_held", mem_addr, 32'h0);
    check("t2_data_held", mem_wdata, 32'h1111_0001);
    gnt = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t2_words", {16'b0, words}, 32'd2);
    check("t2_fetch", {31'b0, fetch_en}, 32'd0);
    check("t2_queue", 32'(exp_q.size()), 32'd0);
    check("t2_req_idle", {31'b0, mem_req}, 32'd0);
    do_reset();

    // Word aborted after 17 bits, then resent whole.
    expect_write(32'h0, 32'hCAFE_0001);
    send_word(32'h0000_0001);
    shift_bits(32'hCAFE_0001, 17);
    end_frame();
    send_word(32'hCAFE_0001);
    send_ck(32'hCAFE_0001);
    end_frame();
    wait_fetch(40);
    check("t3_fetch", {31'b0, fetch_en}, 32'd1);
    check("t3_err", {31'b0, load_err}, 32'd0);
    check("t3_words", {16'b0, words}, 32'd1);
    check("t3_queue", 32'(exp_q.size()), 32'd0);
    do_reset();

    // Empty program: fetch enable with no memory traffic.
    send_word(32'h0000_0000);
    send_ck(32'h0000_0000);
    end_frame();
    wait_fetch(10);
    check("t4_fetch", {31'b0, fetch_en}, 32'd1);
    check("t4_words", {16'b0, words}, 32'd0);
    check("t4_err", {31'b0, load_err}, 32'd0);
    check("t4_state", 32'(dbg_state), 32'(DONE));
    do_reset();

    // Reset pulse mid-word, then a fresh load from the base address.
    expect_write(32'h0, 32'h0A0B_0C0D);
    send_word(32'h0000_0002);
    send_word(32'h0A0B_0C0D);
    shift_bits(32'h55AA_55AA, 10);
    check("t5_pre_words", {16'b0, words}, 32'd1);
    check("t5_pre_addr", mem_addr, 32'h4);
    do_reset();
    check("t5_rst_req", {31'b0, mem_req}, 32'd0);
    check("t5_rst_words", {16'b0, words}, 32'd0);
    check("t5_rst_addr", mem_addr, 32'd0);
    check("t5_rst_wdata", mem_wdata, 32'd0);
    check("t5_rst_fetch", {31'b0, fetch_en}, 32'd0);
    check("t5_rst_err", {31'b0, load_err}, 32'd0);
    check("t5_rst_state", 32'(dbg_state), 32'(IDLE));
    expect_write(32'h0, 32'h1234_5678);
    send_word(32'h0000_0001);
    send_word(32'h1234_5678);
    send_ck(32'h1234_5678);
    end_frame();
    wait_fetch(40);
    check("t5_fetch", {31'b0, fetch_en}, 32'd1);
    check("t5_words", {16'b0, words}, 32'd1);
    check("t5_err", {31'b0, load_err}, 32'd0);
    check("t5_queue", 32'(exp_q.size()), 32'd0);

`ifdef SPI_INST_LOADER_CHECKSUM_EN
    // Checksum good: 1 ^ 3 = 2.
    do_reset();
    expect_write(32'h0, 32'h1);
    expect_write(32'h4, 32'h3);
    send_word(32'h2);
    send_word(32'h1);
    send_word(32'h3);
    send_word(32'h2);
    end_frame();
    wait_fetch(40);
    check("ck_ok_fetch", {31'b0, fetch_en}, 32'd1);
    check("ck_ok_err", {31'b0, load_err}, 32'd0);

    // Checksum bad.
    do_reset();
    expect_write(32'h0, 32'h1);
    expect_write(32'h4, 32'h3);
    send_word(32'h2);
    send_word(32'h1);
    send_word(32'h3);
    send_word(32'h5);
    end_frame();
    repeat (5) @(posedge clk);
    #1;
    check("ck_bad_err", {31'b0, load_err}, 32'd1);
    check("ck_bad_fetch", {31'b0, fetch_en}, 32'd0);
    check("ck_bad_words", {16'b0, words}, 32'd2);
    check("ck_bad_queue", 32'(exp_q.size()), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
